// File: rtl/inst_fetch_pkg.sv
// Shared constants and FSM state type for the instruction fetch stage.
`timescale 1ns/1ps
package inst_fetch_pkg;
  localparam logic [31:0] BUBBLE_INST      = 32'h0000_100F;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [1:0]  BUF_FULL         = 2'd2;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction
endpackage

// File: rtl/inst_fetch_fifo.sv
// Two-entry {inst, pc} FIFO between instruction memory and decode.
`timescale 1ns/1ps
module inst_fifo
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] BUBBLE = BUBBLE_INST
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [31:0] push_inst,
  input  logic [31:0] push_pc,
  output logic [31:0] head_inst,
  output logic [31:0] head_pc,
  output logic [1:0]  count
);
  logic [31:0] inst_mem [2];
  logic [31:0] pc_mem   [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign do_push = push && (count != BUF_FULL);
  assign do_pop  = pop && (count != 2'd0);

  // Flush wins over any same-cycle push or pop.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush && !reset) begin
      inst_mem[wr_ptr] <= push_inst;
      pc_mem[wr_ptr]   <= push_pc;
    end
  end

  assign head_inst = (count != 2'd0) ? inst_mem[rd_ptr] : BUBBLE;
  assign head_pc   = (count != 2'd0) ? pc_mem[rd_ptr]   : 32'h0000_0000;
endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: single-outstanding memory requests, redirect handling
// with a drain state for in-flight responses, and a 2-entry output buffer.
`timescale 1ns/1ps
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] BUBBLE   = BUBBLE_INST
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic        fsm_state
);
  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  target;
  logic [1:0]   count;
  logic         ack_taken;
  logic         push;
  logic         pop;

  // Handshakes: memory side is req/ack with req and addr held until the ack
  // cycle inclusive; decode side transfers when inst_valid && inst_ready.
  assign imem_req   = !reset && ((state == DRAIN) || (count != BUF_FULL));
  assign imem_addr  = pc;
  assign ack_taken  = imem_req && imem_ack;
  assign push       = (state == FETCH) && ack_taken && !redirect;
  assign inst_valid = (count != 2'd0);
  assign pop        = inst_valid && inst_ready;
  assign fsm_state  = logic'(state);

  inst_fifo #(.BUBBLE(BUBBLE)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (redirect),
    .push_inst (imem_rdata),
    .push_pc   (pc),
    .head_inst (inst),
    .head_pc   (inst_pc),
    .count     (count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= FETCH;
      pc     <= word_align(RESET_PC);
      target <= word_align(RESET_PC);
    end else begin
      case (state)
        FETCH: begin
          if (redirect) begin
            // A request still waiting for its ack must finish at the old address.
            if (imem_req && !imem_ack) begin
              state  <= DRAIN;
              target <= word_align(redirect_pc);
            end else begin
              pc <= word_align(redirect_pc);
            end
          end else if (ack_taken) begin
            pc <= pc + 32'd4;
          end
        end
        DRAIN: begin
          if (redirect) target <= word_align(redirect_pc);
          if (ack_taken) begin
            state <= FETCH;
            pc    <= redirect ? word_align(redirect_pc) : target;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end
endmodule
